// File: rtl/instruction_sequencer_pkg.sv
// Shared encodings for the instruction sequencer: stage and opcode values plus
// the bit positions of each instruction-word field.
package instruction_sequencer_pkg;

  typedef enum logic [2:0] {
    StInstrFetch     = 3'd0,
    StImmFetch       = 3'd1,
    StDecode         = 3'd2,
    StMemoryRead     = 3'd3,
    StAlu            = 3'd4,
    StRegisterUpdate = 3'd5,
    StMemoryWrite    = 3'd6,
    StHalted         = 3'd7
  } stage_e;

  typedef enum logic [4:0] {
    InstrNoOp          = 5'd0,
    InstrLoadImmediate = 5'd1,
    InstrLoad          = 5'd2,
    InstrStore         = 5'd3,
    InstrAluOp         = 5'd4,
    InstrHalt          = 5'd5
  } instr_e;

  localparam int unsigned OpcodeLsb = 0;
  localparam int unsigned OpcodeMsb = 4;
  localparam int unsigned RdLsb     = 5;
  localparam int unsigned RdMsb     = 9;
  localparam int unsigned Rs0Lsb    = 10;
  localparam int unsigned Rs0Msb    = 14;
  localparam int unsigned Rs1Lsb    = 15;
  localparam int unsigned Rs1Msb    = 19;
  localparam int unsigned FuncLsb   = 20;
  localparam int unsigned FuncMsb   = 23;

  function automatic logic is_legal(logic [4:0] op);
    return op <= InstrHalt;
  endfunction

endpackage

// File: rtl/instruction_sequencer_field_decode.sv
// Combinational decode of the held instruction word: opcode, register fields,
// ALU function, legality and the stage that follows DECODE.
module instruction_sequencer_field_decode
  import instruction_sequencer_pkg::*;
(
  input  logic [31:0] ir,
  output logic [4:0]  instr_type,
  output logic [4:0]  rd,
  output logic [4:0]  rs0,
  output logic [4:0]  rs1,
  output logic [3:0]  func,
  output logic        illegal,
  output logic [2:0]  next_stage
);

  logic unused_ir_bits;

  assign instr_type     = ir[OpcodeMsb:OpcodeLsb];
  assign rd             = ir[RdMsb:RdLsb];
  assign rs0            = ir[Rs0Msb:Rs0Lsb];
  assign rs1            = ir[Rs1Msb:Rs1Lsb];
  assign func           = ir[FuncMsb:FuncLsb];
  assign illegal        = !is_legal(instr_type);
  assign unused_ir_bits = ^ir[31:24];

  always_comb begin
    next_stage = StHalted;
    case (instr_type)
      InstrNoOp:          next_stage = StInstrFetch;
      InstrLoadImmediate: next_stage = StRegisterUpdate;
      InstrLoad:          next_stage = StMemoryRead;
      InstrStore:         next_stage = StMemoryWrite;
      InstrAluOp:         next_stage = StAlu;
      default:            next_stage = StHalted;
    endcase
  end

endmodule

// File: rtl/instruction_sequencer.sv
// Per-instruction stage machine feeding register_file_control: fetches one or
// two words, decodes, sequences data-memory phases and counts retirements.
module instruction_sequencer
  import instruction_sequencer_pkg::*;
#(
  parameter int unsigned             PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]     RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic [31:0]         imem_data,
  output logic                dmem_req,
  output logic                dmem_we,
  input  logic                dmem_ready,
  output logic [2:0]          stage,
  output logic [4:0]          current_instruction_type,
  output logic [4:0]          load_imm_reg,
  output logic [4:0]          load_mem_reg,
  output logic [4:0]          alu_op_reg_res,
  output logic [4:0]          load_mem_addr_reg,
  output logic [4:0]          alu_op_reg_0,
  output logic [4:0]          store_data_reg,
  output logic [4:0]          alu_op_reg_1,
  output logic [4:0]          store_addr_reg,
  output logic [3:0]          alu_func,
  output logic [31:0]         load_imm_data,
  output logic [PC_WIDTH-1:0] pc,
  output logic                halted,
  output logic                illegal_instr,
  output logic [31:0]         instr_count
);

  localparam logic [PC_WIDTH-1:0] PcOne = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  stage_e              state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [31:0]         ir_q;
  logic [31:0]         imm_q;
  logic                illegal_q;
  logic [31:0]         count_q;

  logic [4:0] dec_type;
  logic [4:0] dec_rd;
  logic [4:0] dec_rs0;
  logic [4:0] dec_rs1;
  logic [3:0] dec_func;
  logic       dec_illegal;
  logic [2:0] dec_next_stage;

  instruction_sequencer_field_decode u_decode (
    .ir         (ir_q),
    .instr_type (dec_type),
    .rd         (dec_rd),
    .rs0        (dec_rs0),
    .rs1        (dec_rs1),
    .func       (dec_func),
    .illegal    (dec_illegal),
    .next_stage (dec_next_stage)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StInstrFetch;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      imm_q     <= '0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      unique case (state_q)
        StInstrFetch: begin
          if (imem_ready) begin
            ir_q    <= imem_data;
            pc_q    <= pc_q + PcOne;
            state_q <= (imem_data[OpcodeMsb:OpcodeLsb] == InstrLoadImmediate) ? StImmFetch
                                                                              : StDecode;
          end
        end
        StImmFetch: begin
          if (imem_ready) begin
            imm_q   <= imem_data;
            pc_q    <= pc_q + PcOne;
            state_q <= StDecode;
          end
        end
        StDecode: begin
          state_q <= stage_e'(dec_next_stage);
          if (dec_illegal) illegal_q <= 1'b1;
          // NO_OP and HALT retire here; every other legal opcode retires later.
          if (dec_type == InstrNoOp || dec_type == InstrHalt) count_q <= count_q + 32'd1;
        end
        StMemoryRead: begin
          if (dmem_ready) state_q <= StRegisterUpdate;
        end
        StAlu: state_q <= StRegisterUpdate;
        StRegisterUpdate: begin
          state_q <= StInstrFetch;
          count_q <= count_q + 32'd1;
        end
        StMemoryWrite: begin
          if (dmem_ready) begin
            state_q <= StInstrFetch;
            count_q <= count_q + 32'd1;
          end
        end
        StHalted: state_q <= StHalted;
      endcase
    end
  end

  assign imem_req  = (state_q == StInstrFetch) || (state_q == StImmFetch);
  assign imem_addr = pc_q;
  assign dmem_req  = (state_q == StMemoryRead) || (state_q == StMemoryWrite);
  assign dmem_we   = (state_q == StMemoryWrite);

  assign stage                    = state_q;
  assign current_instruction_type = dec_type;
  assign load_imm_reg             = dec_rd;
  assign load_mem_reg             = dec_rd;
  assign alu_op_reg_res           = dec_rd;
  assign load_mem_addr_reg        = dec_rs0;
  assign alu_op_reg_0             = dec_rs0;
  assign store_data_reg           = dec_rs0;
  assign alu_op_reg_1             = dec_rs1;
  assign store_addr_reg           = dec_rs1;
  assign alu_func                 = dec_func;
  assign load_imm_data            = imm_q;
  assign pc                       = pc_q;
  assign halted                   = (state_q == StHalted);
  assign illegal_instr            = illegal_q;
  assign instr_count              = count_q;

endmodule
